vrf_read_scheduler: RTL and testbench

- Shares one VRF bank read port among NUM_REQ read requesters (lane read stages) using round-robin arbitration.
- Issues at most one read per cycle and carries each requester's tag through a fixed-latency pipeline matched to the bank read latency.
- Steers returned data back to the originating requester, and can kill in-flight reads by instruction index.
- Sits between the lane's read-stage request queues and the VRF bank read port.

---
 rtl/vrf_read_scheduler_if.sv | 42 ++++
 rtl/vrf_read_scheduler.sv | 137 +++++++++++++
 tb/tb_vrf_read_scheduler.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vrf_read_scheduler_if.sv
// Request, bank-port, kill and response signals of the VRF read scheduler.
// slave is the scheduler's view; master is the view of the surrounding lane logic.
interface vrf_read_scheduler_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned VS_W    = 5,
    parameter int unsigned OFF_W   = 5,
    parameter int unsigned SRC_W   = 4,
    parameter int unsigned IDX_W   = 3,
    parameter int unsigned DATA_W  = 32
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*VS_W-1:0]  req_vs;
    logic [NUM_REQ*OFF_W-1:0] req_offset;
    logic [NUM_REQ*SRC_W-1:0] req_source;
    logic [NUM_REQ*IDX_W-1:0] req_inst_idx;
    logic                     vrf_stall;
    logic                     vrf_rd_en;
    logic [VS_W-1:0]          vrf_rd_vs;
    logic [OFF_W-1:0]         vrf_rd_offset;
    logic [DATA_W-1:0]        vrf_rdata;
    logic                     kill_valid;
    logic [IDX_W-1:0]         kill_inst_idx;
    logic [NUM_REQ-1:0]       resp_valid;
    logic [DATA_W-1:0]        resp_data;
    logic [SRC_W-1:0]         resp_source;
    logic [IDX_W-1:0]         resp_inst_idx;

    modport master (
        output req_valid, req_vs, req_offset, req_source, req_inst_idx,
        output vrf_stall, vrf_rdata, kill_valid, kill_inst_idx,
        input  req_ready, vrf_rd_en, vrf_rd_vs, vrf_rd_offset,
        input  resp_valid, resp_data, resp_source, resp_inst_idx
    );

    modport slave (
        input  req_valid, req_vs, req_offset, req_source, req_inst_idx,
        input  vrf_stall, vrf_rdata, kill_valid, kill_inst_idx,
        output req_ready, vrf_rd_en, vrf_rd_vs, vrf_rd_offset,
        output resp_valid, resp_data, resp_source, resp_inst_idx
    );
endinterface

// File: rtl/vrf_read_scheduler.sv
// Round-robin sharing of one VRF bank read port with a fixed-latency tag pipeline and kill.
// Define VRF_READ_SCHED_PERF_EN to add saturating grant/stall performance counters.
module vrf_read_scheduler #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned VS_W         = 5,
    parameter int unsigned OFF_W        = 5,
    parameter int unsigned SRC_W        = 4,
    parameter int unsigned IDX_W        = 3,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                clock,
    input  logic                reset,
    vrf_read_scheduler_if.slave bus
`ifdef VRF_READ_SCHED_PERF_EN
    ,
    output logic [15:0]         perf_grant_cnt,
    output logic [15:0]         perf_stall_cnt
`endif
);
    localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef struct packed {
        logic             valid;
        logic [ID_W-1:0]  id;
        logic [SRC_W-1:0] source;
        logic [IDX_W-1:0] inst_idx;
    } tag_t;

    logic            reset_q;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic            grant_found;
    logic [ID_W-1:0] grant_id;
    logic            issue;
    int unsigned     cand;
    tag_t            pipe_q [READ_LATENCY];
    tag_t            pipe_d [READ_LATENCY];
    tag_t            pipe_out;
    logic            resp_fire;

    // Scan ptr, ptr+1, ... and take the first valid requester.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (32'(ptr_q) + k) % NUM_REQ;
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(cand);
            end
        end
    end

    // Grants are also blocked in the cycle right after reset drops.
    assign issue = grant_found && !bus.vrf_stall && !reset && !reset_q;

    always_comb begin
        bus.req_ready     = '0;
        bus.vrf_rd_en     = issue;
        bus.vrf_rd_vs     = '0;
        bus.vrf_rd_offset = '0;
        ptr_d             = ptr_q;
        if (issue) begin
            bus.req_ready[grant_id] = 1'b1;
            bus.vrf_rd_vs           = bus.req_vs[32'(grant_id)*VS_W +: VS_W];
            bus.vrf_rd_offset       = bus.req_offset[32'(grant_id)*OFF_W +: OFF_W];
            ptr_d = (32'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
        end
    end

    always_comb begin
        pipe_d[0].id       = grant_id;
        pipe_d[0].source   = bus.req_source[32'(grant_id)*SRC_W +: SRC_W];
        pipe_d[0].inst_idx = bus.req_inst_idx[32'(grant_id)*IDX_W +: IDX_W];
        // A read issued alongside a matching kill still goes to the bank but carries no response.
        pipe_d[0].valid    = issue &&
            !(bus.kill_valid && (pipe_d[0].inst_idx == bus.kill_inst_idx));
        for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            pipe_d[i]       = pipe_q[i-1];
            pipe_d[i].valid = pipe_q[i-1].valid &&
                !(bus.kill_valid && (pipe_q[i-1].inst_idx == bus.kill_inst_idx));
        end
    end

    always_ff @(posedge clock) begin
        reset_q <= reset;
        if (reset) begin
            ptr_q <= '0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign pipe_out  = pipe_q[READ_LATENCY-1];
    assign resp_fire = pipe_out.valid && !reset;

    always_comb begin
        bus.resp_valid    = '0;
        bus.resp_data     = '0;
        bus.resp_source   = '0;
        bus.resp_inst_idx = '0;
        if (resp_fire) begin
            bus.resp_valid[pipe_out.id] = 1'b1;
            bus.resp_data               = bus.vrf_rdata;
            bus.resp_source             = pipe_out.source;
            bus.resp_inst_idx           = pipe_out.inst_idx;
        end
    end

`ifdef VRF_READ_SCHED_PERF_EN
    logic [15:0] grant_cnt_q, stall_cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (issue && (grant_cnt_q != 16'hFFFF)) begin
                grant_cnt_q <= grant_cnt_q + 16'd1;
            end
            if ((|bus.req_valid) && bus.vrf_stall && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign perf_grant_cnt = grant_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_vrf_read_scheduler.sv
// Directed bench for vrf_read_scheduler: arbitration vector table plus hand-written
// latency, kill, mid-operation reset and (when enabled) performance counter sequences.
module tb_vrf_read_scheduler;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    vrf_read_scheduler_if #(
        .NUM_REQ(4), .VS_W(5), .OFF_W(5), .SRC_W(4), .IDX_W(3), .DATA_W(32)
    ) bus ();

`ifdef VRF_READ_SCHED_PERF_EN
    logic [15:0] perf_grant_cnt, perf_stall_cnt;
`endif

    vrf_read_scheduler #(
        .NUM_REQ(4), .VS_W(5), .OFF_W(5), .SRC_W(4), .IDX_W(3), .DATA_W(32),
        .READ_LATENCY(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
`ifdef VRF_READ_SCHED_PERF_EN
        ,
        .perf_grant_cnt(perf_grant_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    typedef struct {
        logic [3:0] valid;
        logic       stall;
        logic [3:0] exp_ready;
    } arb_vec_t;

    arb_vec_t arb_tab [22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] vs, input logic [4:0] off,
                           input logic [3:0] src, input logic [2:0] idx);
        bus.req_vs[i*5 +: 5]       = vs;
        bus.req_offset[i*5 +: 5]   = off;
        bus.req_source[i*4 +: 4]   = src;
        bus.req_inst_idx[i*3 +: 3] = idx;
    endtask

    task automatic idle(input int n);
        bus.req_valid = 4'b0000;
        bus.vrf_stall = 1'b0;
        bus.kill_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [4:0] exp_vs;
        logic [4:0] exp_off;

        arb_tab[0]  = '{4'b1111, 1'b0, 4'b0001};
        arb_tab[1]  = '{4'b1111, 1'b0, 4'b0010};
        arb_tab[2]  = '{4'b1111, 1'b0, 4'b0100};
        arb_tab[3]  = '{4'b1111, 1'b0, 4'b1000};
        arb_tab[4]  = '{4'b1111, 1'b0, 4'b0001};
        arb_tab[5]  = '{4'b1111, 1'b0, 4'b0010};
        arb_tab[6]  = '{4'b1111, 1'b0, 4'b0100};
        arb_tab[7]  = '{4'b1111, 1'b0, 4'b1000};
        arb_tab[8]  = '{4'b0011, 1'b1, 4'b0000};
        arb_tab[9]  = '{4'b0011, 1'b1, 4'b0000};
        arb_tab[10] = '{4'b0011, 1'b1, 4'b0000};
        arb_tab[11] = '{4'b0011, 1'b0, 4'b0001};
        arb_tab[12] = '{4'b0011, 1'b0, 4'b0010};
        arb_tab[13] = '{4'b0011, 1'b0, 4'b0001};
        arb_tab[14] = '{4'b0000, 1'b0, 4'b0000};
        arb_tab[15] = '{4'b1010, 1'b0, 4'b0010};
        arb_tab[16] = '{4'b1010, 1'b0, 4'b1000};
        arb_tab[17] = '{4'b0100, 1'b0, 4'b0100};
        arb_tab[18] = '{4'b0100, 1'b0, 4'b0100};
        arb_tab[19] = '{4'b0100, 1'b0, 4'b0100};
        arb_tab[20] = '{4'b1001, 1'b1, 4'b0000};
        arb_tab[21] = '{4'b1001, 1'b0, 4'b1000};

        bus.req_valid     = 4'b1111;
        bus.vrf_stall     = 1'b0;
        bus.vrf_rdata     = 32'h0;
        bus.kill_valid    = 1'b0;
        bus.kill_inst_idx = 3'd0;
        for (int i = 0; i < 4; i++) set_req(i, 5'(10 + i), 5'(20 + i), 4'(i), 3'(i));

        // Reset cycle and the cycle after it: no grants, no responses.
        reset = 1'b1;
        tick();
        #2;
        chk("reset_ready", 32'(bus.req_ready), 32'h0);
        chk("reset_rd_en", 32'(bus.vrf_rd_en), 32'h0);
        chk("reset_resp_valid", 32'(bus.resp_valid), 32'h0);
        chk("reset_resp_data", bus.resp_data, 32'h0);
        tick();
        reset = 1'b0;
        #2;
        chk("post_reset_ready", 32'(bus.req_ready), 32'h0);
        chk("post_reset_rd_en", 32'(bus.vrf_rd_en), 32'h0);
        tick();

        for (int v = 0; v < 22; v++) begin
            bus.req_valid = arb_tab[v].valid;
            bus.vrf_stall = arb_tab[v].stall;
            exp_vs  = 5'd0;
            exp_off = 5'd0;
            for (int i = 0; i < 4; i++) begin
                if (arb_tab[v].exp_ready[i]) begin
                    exp_vs  = 5'(10 + i);
                    exp_off = 5'(20 + i);
                end
            end
            #2;
            chk($sformatf("arb_ready[%0d]", v), 32'(bus.req_ready), 32'(arb_tab[v].exp_ready));
            chk($sformatf("arb_rd_en[%0d]", v), 32'(bus.vrf_rd_en),
                32'(arb_tab[v].exp_ready != 4'b0000));
            chk($sformatf("arb_vs[%0d]", v), 32'(bus.vrf_rd_vs), 32'(exp_vs));
            chk($sformatf("arb_off[%0d]", v), 32'(bus.vrf_rd_offset), 32'(exp_off));
            tick();
        end

        // Single read from requester 2, response exactly two cycles later.
        idle(3);
        #2;
        chk("idle_resp_valid", 32'(bus.resp_valid), 32'h0);
        set_req(2, 5'd7, 5'd3, 4'hA, 3'd5);
        bus.req_valid = 4'b0100;
        #2;
        chk("lat_ready", 32'(bus.req_ready), 32'h4);
        chk("lat_vs", 32'(bus.vrf_rd_vs), 32'd7);
        chk("lat_off", 32'(bus.vrf_rd_offset), 32'd3);
        tick();
        bus.req_valid = 4'b0000;
        #2;
        chk("lat_early", 32'(bus.resp_valid), 32'h0);
        tick();
        bus.vrf_rdata = 32'hDEADBEEF;
        #2;
        chk("lat_resp_valid", 32'(bus.resp_valid), 32'h4);
        chk("lat_resp_data", bus.resp_data, 32'hDEADBEEF);
        chk("lat_resp_source", 32'(bus.resp_source), 32'hA);
        chk("lat_resp_idx", 32'(bus.resp_inst_idx), 32'd5);
        tick();
        #2;
        chk("lat_after_valid", 32'(bus.resp_valid), 32'h0);
        chk("lat_after_data", bus.resp_data, 32'h0);

        // Issues of idx 3,4,3 with kill of idx 3 in the third-issue cycle or the one after.
        for (int ka = 2; ka <= 3; ka++) begin
            idle(3);
            bus.kill_inst_idx = 3'd3;
            for (int c = 0; c < 6; c++) begin
                bus.req_valid = (c < 3) ? 4'b0001 : 4'b0000;
                set_req(0, 5'd1, 5'd2, 4'h6, (c == 1) ? 3'd4 : 3'd3);
                bus.kill_valid = (c == ka);
                bus.vrf_rdata = 32'h1000 + 32'(c);
                #2;
                if (c == 0) chk($sformatf("kill%0d_c0", ka), 32'(bus.resp_valid), 32'h0);
                if (c == 2) begin
                    chk($sformatf("kill%0d_issue3", ka), 32'(bus.vrf_rd_en), 32'h1);
                    chk($sformatf("kill%0d_r0_valid", ka), 32'(bus.resp_valid), 32'h1);
                    chk($sformatf("kill%0d_r0_idx", ka), 32'(bus.resp_inst_idx), 32'd3);
                    chk($sformatf("kill%0d_r0_src", ka), 32'(bus.resp_source), 32'h6);
                    chk($sformatf("kill%0d_r0_data", ka), bus.resp_data, 32'h1002);
                end
                if (c == 3) begin
                    chk($sformatf("kill%0d_r1_valid", ka), 32'(bus.resp_valid), 32'h1);
                    chk($sformatf("kill%0d_r1_idx", ka), 32'(bus.resp_inst_idx), 32'd4);
                    chk($sformatf("kill%0d_r1_data", ka), bus.resp_data, 32'h1003);
                end
                if (c >= 4) chk($sformatf("kill%0d_c%0d", ka, c), 32'(bus.resp_valid), 32'h0);
                tick();
            end
            bus.kill_valid = 1'b0;
        end

        // Reset with two reads in flight drops them and restores requester-0 priority.
        idle(3);
        bus.vrf_rdata = 32'h5555AAAA;
        bus.req_valid = 4'b0001;
        tick();
        tick();
        reset = 1'b1;
        bus.req_valid = 4'b1111;
        #2;
        chk("mid_reset_resp", 32'(bus.resp_valid), 32'h0);
        chk("mid_reset_ready", 32'(bus.req_ready), 32'h0);
        tick();
        reset = 1'b0;
        #2;
        chk("mid_post_resp", 32'(bus.resp_valid), 32'h0);
        chk("mid_post_ready", 32'(bus.req_ready), 32'h0);
        tick();
        #2;
        chk("mid_resume_resp", 32'(bus.resp_valid), 32'h0);
        chk("mid_resume_ready", 32'(bus.req_ready), 32'h1);
        tick();

`ifdef VRF_READ_SCHED_PERF_EN
        idle(1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        bus.req_valid = 4'b0001;
        for (int i = 0; i < 10; i++) tick();
        bus.vrf_stall = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        bus.req_valid = 4'b0000;
        tick();
        tick();
        bus.vrf_stall = 1'b0;
        #2;
        chk("perf_grant", 32'(perf_grant_cnt), 32'd10);
        chk("perf_stall", 32'(perf_stall_cnt), 32'd4);
        tick();
        bus.req_valid = 4'b0001;
        for (int i = 0; i < 65540; i++) tick();
        bus.req_valid = 4'b0000;
        #2;
        chk("perf_grant_sat", 32'(perf_grant_cnt), 32'hFFFF);
        chk("perf_stall_hold", 32'(perf_stall_cnt), 32'd4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
